// File: rtl/mult_booth.sv
// Signed 32x32 multiplier, radix-2 Booth, one step per clock.
// MULT_EARLY_ZERO_EN: zero operand skips straight to DONE.
module mult_booth (
   input  logic        clk,
   input  logic        Reset,
   input  logic        MultControl,
   input  logic [31:0] AFio,
   input  logic [31:0] BFio,
   output logic [31:0] MultHiFio,
   output logic [31:0] MultLoFio,
   output logic        MultBusy,
   output logic        MultDone
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [32:0] m;
   logic [65:0] p;
   logic [4:0]  count;
   logic [32:0] acc;
   logic [65:0] p_step;
   logic        zero_start;

`ifdef MULT_EARLY_ZERO_EN
   assign zero_start = (AFio == 32'd0) || (BFio == 32'd0);
`else
   assign zero_start = 1'b0;
`endif

   assign MultBusy = (state != IDLE);

   // One Booth step: 33-bit add/sub on the upper half, then arithmetic shift.
   always_comb begin
      acc = p[65:33];
      case (p[1:0])
         2'b01:   acc = p[65:33] + m;
         2'b10:   acc = p[65:33] - m;
         default: acc = p[65:33];
      endcase
      p_step = {acc[32], acc, p[32:1]};
   end

   // Control FSM, datapath registers and registered result/done outputs.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= IDLE;
         count     <= 5'd0;
         p         <= 66'd0;
         m         <= 33'd0;
         MultHiFio <= 32'd0;
         MultLoFio <= 32'd0;
         MultDone  <= 1'b0;
      end else begin
         MultDone <= 1'b0;
         case (state)
            IDLE: begin
               if (MultControl) begin
                  m     <= {AFio[31], AFio};
                  count <= 5'd31;
                  if (zero_start) begin
                     p     <= 66'd0;
                     state <= DONE;
                  end else begin
                     p     <= {33'd0, BFio, 1'b0};
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               p <= p_step;
               if (count == 5'd0)
                  state <= DONE;
               else
                  count <= count - 5'd1;
            end
            DONE: begin
               MultHiFio <= p[64:33];
               MultLoFio <= p[32:1];
               MultDone  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_booth.sv
// Randomized self-checking bench for mult_booth.
// Reference product is plain signed 64-bit multiplication.
module tb_mult_booth;

   logic        clk;
   logic        Reset;
   logic        MultControl;
   logic [31:0] AFio;
   logic [31:0] BFio;
   logic [31:0] MultHiFio;
   logic [31:0] MultLoFio;
   logic        MultBusy;
   logic        MultDone;

   int n_checks = 0;
   int n_fail   = 0;

   mult_booth dut (
      .clk(clk),
      .Reset(Reset),
      .MultControl(MultControl),
      .AFio(AFio),
      .BFio(BFio),
      .MultHiFio(MultHiFio),
      .MultLoFio(MultLoFio),
      .MultBusy(MultBusy),
      .MultDone(MultDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a,
                                         input logic [31:0] b);
      longint pa, pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
   endfunction

   function automatic int want_lat(input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULT_EARLY_ZERO_EN
      if (a == 32'd0 || b == 32'd0) return 1;
`endif
      return 33;
   endfunction

   // waits up to 100 edges for MultDone; returns edge count or 0
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (MultDone) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int lat;
      AFio        = a;
      BFio        = b;
      MultControl = 1'b1;
      @(posedge clk);
      #1;
      MultControl = 1'b0;
      AFio        = $urandom;
      BFio        = $urandom;
      check({tag, "_busy"}, 64'(MultBusy), 64'd1);
      wait_done(lat);
      check({tag, "_lat"}, 64'(lat), 64'(want_lat(a, b)));
      check({tag, "_prod"}, {MultHiFio, MultLoFio}, model(a, b));
      check({tag, "_idle"}, 64'(MultBusy), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(MultDone), 64'd0);
      check({tag, "_hold"}, {MultHiFio, MultLoFio}, model(a, b));
   endtask

   initial begin
      int lat;
      int pulses;
      logic [31:0] a;
      logic [31:0] b;

      Reset       = 1'b1;
      MultControl = 1'b1;
      AFio        = 32'd5;
      BFio        = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(MultBusy), 64'd0);
      check("rst_done", 64'(MultDone), 64'd0);
      check("rst_prod", {MultHiFio, MultLoFio}, 64'd0);
      Reset       = 1'b0;
      MultControl = 1'b0;

      run_op(32'd3, 32'd5, "a3b5");
      run_op(32'hFFFFFFF9, 32'd6, "neg7x6");
      run_op(32'h80000000, 32'h80000000, "minxmin");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "m1xm1");
      run_op(32'd0, 32'h1234, "zero_a");
      run_op(32'h1234, 32'd0, "zero_b");

      // abort mid-operation with reset at edge N+10
      AFio        = 32'd123;
      BFio        = 32'd456;
      MultControl = 1'b1;
      @(posedge clk);
      #1;
      MultControl = 1'b0;
      pulses      = 0;
      repeat (9) begin
         @(posedge clk);
         #1;
         if (MultDone) pulses++;
      end
      Reset = 1'b1;
      @(posedge clk);
      #1;
      Reset = 1'b0;
      check("abort_pulse", 64'(pulses), 64'd0);
      check("abort_busy", 64'(MultBusy), 64'd0);
      check("abort_done", 64'(MultDone), 64'd0);
      check("abort_prod", {MultHiFio, MultLoFio}, 64'd0);
      run_op(32'd2, 32'hFFFFFFFD, "after_rst");

      // second request while busy must be ignored
      AFio        = 32'd4;
      BFio        = 32'd4;
      MultControl = 1'b1;
      @(posedge clk);
      #1;
      MultControl = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      AFio        = 32'd9;
      MultControl = 1'b1;
      @(posedge clk);
      #1;
      MultControl = 1'b0;
      pulses      = 0;
      for (int k = 6; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (MultDone) pulses++;
      end
      check("ign_pulses", 64'(pulses), 64'd1);
      check("ign_prod", {MultHiFio, MultLoFio}, 64'h10);

      // held request restarts on the first IDLE edge after completion
      AFio        = 32'd7;
      BFio        = 32'hFFFFFFF5;
      MultControl = 1'b1;
      @(posedge clk);
      #1;
      wait_done(lat);
      check("hold_lat1", 64'(lat), 64'd33);
      check("hold_prod1", {MultHiFio, MultLoFio}, model(32'd7, 32'hFFFFFFF5));
      AFio = 32'd100;
      BFio = 32'd3;
      wait_done(lat);
      MultControl = 1'b0;
      check("hold_gap", 64'(lat), 64'd34);
      check("hold_prod2", {MultHiFio, MultLoFio}, 64'd300);
      repeat (3) @(posedge clk);
      #1;
      check("hold_stop", 64'(MultBusy), 64'd0);

      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 4) == 0) a = 32'd0;
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         if ($urandom_range(0, 4) == 0) b = 32'h80000000;
         run_op(a, b, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port MultControl, input, 1 bit: start request, sampled only in IDLE.
REQ-004 The block SHALL have port AFio, input, 32 bits: multiplicand, two's complement.
REQ-005 The block SHALL have port BFio, input, 32 bits: multiplier, two's complement.
REQ-006 The block SHALL have port MultHiFio, output reg, 32 bits: product bits 63:32.
REQ-007 The block SHALL have port MultLoFio, output reg, 32 bits: product bits 31:0.
REQ-008 The block SHALL have port MultBusy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port MultDone, output reg, 1 bit: one-cycle completion pulse.

Function
REQ-010 The block SHALL compute the signed 64-bit product AFio*BFio using radix-2 Booth recoding, one step per clock.
REQ-011 The block SHALL implement states IDLE, RUN and DONE in a 2-bit state register; the remaining encoding SHALL return to IDLE.
REQ-012 IDLE with MultControl=1 at edge N SHALL have these effects:
- latch M = AFio sign-extended to 33 bits;
- load P (66 bits) = {33'b0, BFio, 1'b0};
- load the 5-bit counter with 31;
- go to RUN.
REQ-013 Each RUN edge SHALL perform one Booth step:
- P[1:0]=01: P[65:33] += M;
- P[1:0]=10: P[65:33] -= M;
- 00 or 11: no add;
- then arithmetic shift P right by 1 (bit 65 replicated).
REQ-014 All accumulator arithmetic SHALL be 33-bit so that 0x80000000*0x80000000 does not overflow.
REQ-015 RUN SHALL last exactly 32 edges (N+1..N+32); on the edge where the counter is 0 the state SHALL go to DONE, otherwise the counter decrements.
REQ-016 At edge N+33 (DONE) the block SHALL do all of the following:
- MultHiFio = P[64:33];
- MultLoFio = P[32:1];
- MultDone = 1 for exactly one cycle;
- go to IDLE.
REQ-017 MultDone SHALL be 0 on every edge other than the DONE edge.
REQ-018 MultBusy SHALL be high from after edge N until after edge N+33.
REQ-019 MultControl asserted while MultBusy=1 SHALL be ignored, with no restart and no queuing.
REQ-020 MultControl held high continuously SHALL start a new operation on the first IDLE edge after completion (edge N+34).
REQ-021 MultHiFio/MultLoFio SHALL hold their last result until the next DONE edge or Reset.
REQ-022 AFio/BFio changes after edge N SHALL NOT affect the operation in progress.

Reset
REQ-023 Reset=1 at a rising edge SHALL override everything, including MultControl and any state:
- state=IDLE, counter=0, P=0, M=0;
- MultHiFio=0, MultLoFio=0, MultDone=0.
REQ-024 Reset mid-operation SHALL abort the operation with no MultDone pulse; a start on the first edge after Reset deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro MULT_EARLY_ZERO_EN SHALL select early zero detection.
- When defined: in IDLE, start with AFio==0 or BFio==0 SHALL go directly to DONE with P cleared, so MultDone pulses at edge N+1 with Hi=Lo=0 and MultBusy high for one cycle.
- When undefined: every operation SHALL take the full 33-edge latency, including zero operands.

Verification
REQ-026 Start with A=3, B=5: Hi=0x00000000, Lo=0x0000000F; MultDone high exactly at edge N+33; MultBusy low after.
REQ-027 Start with A=0xFFFFFFF9 (-7), B=6: Hi=0xFFFFFFFF, Lo=0xFFFFFFD6.
REQ-028 Start with A=B=0x80000000: Hi=0x40000000, Lo=0x00000000; start with A=B=0xFFFFFFFF: Hi=0, Lo=1.
REQ-029 Reset asserted at edge N+10:
- MultBusy=0, Hi=Lo=0, no MultDone pulse;
- a following start with A=2, B=-3 gives Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
REQ-030 Start with A=4, B=4, then a second MultControl with A=9 at edge N+5: ignored; result Lo=0x10; single MultDone.
REQ-031 A=0, B=0x1234 with MULT_EARLY_ZERO_EN: MultDone at edge N+1, Hi=Lo=0. Without the macro: MultDone at edge N+33, Hi=Lo=0.
